// File: rtl/pe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_arbiter
// Purpose  : Shares one priority_encoder between N_REQ requesters. Arbitrates
//            search words, issues one word per cycle to the encoder, keeps the
//            issuing requester IDs in a tag FIFO and routes each encoder result
//            back to its owner.
// Config   : PE_ARB_RR_EN defined   -> round-robin arbitration
//            PE_ARB_RR_EN undefined -> fixed priority (lowest index wins)
// Revision : 1.0 - initial release
// ============================================================================
module pe_arbiter #(
    parameter int WIDTH        = 16,
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [N_REQ*WIDTH-1:0]     req_data_i,
    input  logic [N_REQ-1:0]           req_val_i,
    output logic [N_REQ-1:0]           req_rdy_o,
    output logic [WIDTH-1:0]           pe_data_o,
    output logic                       pe_data_val_o,
    input  logic [WIDTH-1:0]           pe_left_i,
    input  logic [WIDTH-1:0]           pe_right_i,
    input  logic                       pe_val_i,
    output logic [WIDTH-1:0]           rsp_left_o,
    output logic [WIDTH-1:0]           rsp_right_o,
    output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
    output logic [N_REQ-1:0]           rsp_val_o,
    output logic                       err_o
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int AW   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);

    localparam logic [CW-1:0]   C_CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [AW-1:0]   C_PTR_LST = AW'(MAX_INFLIGHT - 1);
    localparam logic [ID_W-1:0] C_ID_LST  = ID_W'(N_REQ - 1);

    // Tag FIFO state
    logic [ID_W-1:0]  r_tag [MAX_INFLIGHT];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    // Issue / response registers
    logic [WIDTH-1:0] r_pe_data;
    logic             r_pe_data_val;
    logic [WIDTH-1:0] r_rsp_left;
    logic [WIDTH-1:0] r_rsp_right;
    logic [ID_W-1:0]  r_rsp_id;
    logic [N_REQ-1:0] r_rsp_val;
    logic             r_err;

    // Combinational control
    logic             w_can_issue;
    logic             w_gnt_vld;
    logic [ID_W-1:0]  w_gnt_id;
    logic [WIDTH-1:0] w_gnt_data;
    logic             w_push;
    logic             w_pop;
    logic             w_stray;
    logic [ID_W-1:0]  w_head;

    // A pop at full frees a slot in the same cycle, so issue may continue.
    assign w_can_issue = (r_cnt < C_CNT_MAX) || pe_val_i;
    assign w_pop       = pe_val_i && (r_cnt != '0);
    assign w_stray     = pe_val_i && (r_cnt == '0);
    assign w_push      = w_gnt_vld;
    assign w_head      = r_tag[r_rd_ptr];

`ifdef PE_ARB_RR_EN
    logic [ID_W-1:0] r_ptr;

    // Round-robin search starting at r_ptr, wrapping modulo N_REQ
    always_comb begin
        logic [ID_W:0] w_idx;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            if (!w_gnt_vld && req_val_i[w_idx[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx[ID_W-1:0];
            end
        end
        if (srst_i || !w_can_issue) begin
            w_gnt_vld = 1'b0;
            w_gnt_id  = '0;
        end
    end

    // Advance the pointer past the requester just served
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_ptr <= (w_gnt_id == C_ID_LST) ? '0 : w_gnt_id + 1'b1;
        end
    end
`else
    // Fixed priority: lowest requester index wins (descending scan, last hit kept)
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_val_i[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ID_W'(k);
            end
        end
        if (srst_i || !w_can_issue) begin
            w_gnt_vld = 1'b0;
            w_gnt_id  = '0;
        end
    end
`endif

    // Select the granted requester's word
    always_comb begin
        w_gnt_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt_id == ID_W'(k)) begin
                w_gnt_data = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign req_rdy_o = w_gnt_vld ? (N_REQ'(1) << w_gnt_id) : '0;

    // Tag FIFO storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_gnt_id;
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_LST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_LST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Issue register toward the encoder; data holds when nothing is issued
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_pe_data     <= '0;
            r_pe_data_val <= 1'b0;
        end else begin
            r_pe_data_val <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_pe_data <= w_gnt_data;
            end
        end
    end

    // Response register: route encoder result to the FIFO head's owner
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rsp_left  <= '0;
            r_rsp_right <= '0;
            r_rsp_id    <= '0;
            r_rsp_val   <= '0;
        end else if (w_pop) begin
            r_rsp_left  <= pe_left_i;
            r_rsp_right <= pe_right_i;
            r_rsp_id    <= w_head;
            r_rsp_val   <= N_REQ'(1) << w_head;
        end else begin
            r_rsp_val   <= '0;
        end
    end

    // Sticky error: encoder result with no outstanding tag
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_err <= 1'b0;
        end else if (w_stray) begin
            r_err <= 1'b1;
        end
    end

    assign pe_data_o     = r_pe_data;
    assign pe_data_val_o = r_pe_data_val;
    assign rsp_left_o    = r_rsp_left;
    assign rsp_right_o   = r_rsp_right;
    assign rsp_id_o      = r_rsp_id;
    assign rsp_val_o     = r_rsp_val;
    assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_arbiter
// Purpose  : Self-checking bench for pe_arbiter with an encoder stand-in of
//            programmable latency and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_arbiter;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int MAX = 4;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]  req_val_i;
    logic [N-1:0]  req_rdy_o;
    logic [W-1:0]  pe_data_o;
    logic          pe_data_val_o;
    logic [W-1:0]  pe_left_i;
    logic [W-1:0]  pe_right_i;
    logic          pe_val_i;
    logic [W-1:0]  rsp_left_o;
    logic [W-1:0]  rsp_right_o;
    logic [1:0]    rsp_id_o;
    logic [N-1:0]  rsp_val_o;
    logic          err_o;

    pe_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_INFLIGHT(MAX)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .req_data_i(req_data_i), .req_val_i(req_val_i), .req_rdy_o(req_rdy_o),
        .pe_data_o(pe_data_o), .pe_data_val_o(pe_data_val_o),
        .pe_left_i(pe_left_i), .pe_right_i(pe_right_i), .pe_val_i(pe_val_i),
        .rsp_left_o(rsp_left_o), .rsp_right_o(rsp_right_o),
        .rsp_id_o(rsp_id_o), .rsp_val_o(rsp_val_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [W-1:0] w; int due; } enc_t;
    typedef struct { int id; logic [W-1:0] l; logic [W-1:0] r; int c; } rsp_t;

    enc_t  encq[$];
    int    tagq[$];
    rsp_t  rlog[$];
    logic [W-1:0] rq_data [N];
    bit    rq_pend [N];
    bit    stray;
    int    lat, cyc, ptr_m;
    int    n_pass, n_chk;
    logic [N-1:0] obs_rdy;

    logic [W-1:0] e_pe_data, e_left, e_right;
    logic         e_pe_val, e_err;
    int           e_id;
    logic [N-1:0] e_rsp_val;

    function automatic logic [W-1:0] leftmost(input logic [W-1:0] x);
        leftmost = '0;
        for (int i = 0; i < W; i++) if (x[i]) leftmost = W'(1) << i;
    endfunction

    function automatic logic [W-1:0] rightmost(input logic [W-1:0] x);
        rightmost = x & (~x + W'(1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic refill(input int pct);
        for (int i = 0; i < N; i++) begin
            if (!rq_pend[i] && ($urandom % 100) < pct) begin
                rq_pend[i] = 1'b1;
                rq_data[i] = W'($urandom);
            end
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) rq_pend[i] = 1'b0;
    endtask

    // One clock cycle: drive, check combinational grant, advance model, check registers
    task automatic tick(input bit rst);
        logic [W-1:0] w;
        bit pv;
        int g, h;
        srst_i = rst;
        for (int i = 0; i < N; i++) begin
            req_val_i[i]          = rq_pend[i];
            req_data_i[i*W +: W]  = rq_data[i];
        end
        pv = 1'b0;
        w  = '0;
        if (rst) encq.delete();
        if (!rst && encq.size() > 0 && encq[0].due == cyc) begin
            pv = 1'b1;
            w  = encq[0].w;
            void'(encq.pop_front());
        end
        if (stray) begin
            pv = 1'b1;
            w  = W'($urandom);
        end
        pe_val_i   = pv;
        pe_left_i  = leftmost(w);
        pe_right_i = rightmost(w);
        #1;
        g = -1;
        if (!rst && (tagq.size() < MAX || pv)) begin
`ifdef PE_ARB_RR_EN
            for (int k = N - 1; k >= 0; k--)
                if (rq_pend[(ptr_m + k) % N]) g = (ptr_m + k) % N;
`else
            for (int k = N - 1; k >= 0; k--)
                if (rq_pend[k]) g = k;
`endif
        end
        obs_rdy = req_rdy_o;
        chk("req_rdy", req_rdy_o, (g >= 0) ? (N'(1) << g) : '0);
        if (rst) begin
            tagq.delete();
            ptr_m = 0; e_pe_data = '0; e_pe_val = 0; e_left = '0; e_right = '0;
            e_id = 0; e_rsp_val = '0; e_err = 0;
        end else begin
            e_rsp_val = '0;
            if (pv) begin
                if (tagq.size() > 0) begin
                    h = tagq.pop_front();
                    e_left = leftmost(w); e_right = rightmost(w);
                    e_id = h; e_rsp_val = N'(1) << h;
                end else begin
                    e_err = 1'b1;
                end
            end
            e_pe_val = (g >= 0);
            if (g >= 0) begin
                tagq.push_back(g);
                e_pe_data  = rq_data[g];
                ptr_m      = (g + 1) % N;
                rq_pend[g] = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
        chk("pe_data_val", pe_data_val_o, e_pe_val);
        chk("pe_data", pe_data_o, e_pe_data);
        chk("rsp_val", rsp_val_o, e_rsp_val);
        chk("rsp_id", rsp_id_o, e_id);
        chk("rsp_left", rsp_left_o, e_left);
        chk("rsp_right", rsp_right_o, e_right);
        chk("err", err_o, e_err);
        if (pe_data_val_o === 1'b1) encq.push_back('{pe_data_o, cyc + lat});
        if (rsp_val_o != '0) rlog.push_back('{int'(rsp_id_o), rsp_left_o, rsp_right_o, cyc});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((tagq.size() > 0 || encq.size() > 0) && t < 100) begin
            tick(1'b0);
            t++;
        end
        chk("drain_timeout", (t < 100), 1);
        tick(1'b0);
    endtask

    int g0;
    logic [N-1:0] rec [12];

    initial begin
        n_pass = 0; n_chk = 0; cyc = 0; lat = 1; ptr_m = 0; stray = 0;
        srst_i = 1'b1; req_val_i = '0; req_data_i = '0; pe_val_i = 1'b0;
        pe_left_i = '0; pe_right_i = '0;
        for (int i = 0; i < N; i++) begin rq_pend[i] = 1'b1; rq_data[i] = W'($urandom); end

        // Reset with requests pending: grant must stay low
        tick(1'b1);
        tick(1'b1);
        clear_reqs();

        // Single request from requester 2
        rlog.delete();
        rq_pend[2] = 1'b1; rq_data[2] = 16'h0A50;
        g0 = cyc;
        tick(1'b0);
        chk("single_rdy", obs_rdy, 4'b0100);
        drain();
        chk("single_cnt", rlog.size(), 1);
        if (rlog.size() > 0) begin
            chk("single_lat", rlog[0].c, g0 + 3);
            chk("single_id", rlog[0].id, 2);
            chk("single_left", rlog[0].l, 16'h0800);
            chk("single_right", rlog[0].r, 16'h0010);
        end

        // Fairness: all requesters continuously valid
        tick(1'b1);
        for (int k = 0; k < 8; k++) begin
            refill(100);
            tick(1'b0);
`ifdef PE_ARB_RR_EN
            chk("fair_grant", obs_rdy, N'(1) << (k % N));
`else
            chk("fair_grant", obs_rdy, 4'b0001);
`endif
        end
        clear_reqs();
        drain();

        // Back-pressure with a slow encoder
        tick(1'b1);
        lat = 6;
        for (int k = 0; k < 12; k++) begin
            refill(100);
            tick(1'b0);
            rec[k] = obs_rdy;
        end
        for (int k = 0; k < 4; k++) chk("bp_issue", (rec[k] != '0), 1);
        for (int k = 4; k < 7; k++) chk("bp_stall", rec[k], 4'b0000);
        chk("bp_resume", (rec[7] != '0), 1);
        clear_reqs();
        drain();

        // Result routing
        tick(1'b1);
        lat = 1;
        rlog.delete();
        rq_pend[0] = 1'b1; rq_data[0] = 16'h0001; tick(1'b0);
        rq_pend[3] = 1'b1; rq_data[3] = 16'h8000; tick(1'b0);
        rq_pend[1] = 1'b1; rq_data[1] = 16'h0000; tick(1'b0);
        drain();
        chk("route_cnt", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("route0", {rlog[0].id[7:0], rlog[0].l, rlog[0].r}, {8'd0, 16'h0001, 16'h0001});
            chk("route1", {rlog[1].id[7:0], rlog[1].l, rlog[1].r}, {8'd3, 16'h8000, 16'h8000});
            chk("route2", {rlog[2].id[7:0], rlog[2].l, rlog[2].r}, {8'd1, 16'h0000, 16'h0000});
        end

        // Randomized traffic at several encoder latencies
        for (int r = 0; r < 4; r++) begin
            lat = $urandom_range(1, 6);
            for (int k = 0; k < 80; k++) begin
                refill(60);
                tick(1'b0);
            end
            clear_reqs();
            drain();
        end

        // Stray encoder result with an empty FIFO
        rlog.delete();
        stray = 1'b1;
        tick(1'b0);
        stray = 1'b0;
        chk("err_set", err_o, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0);
        chk("err_sticky", err_o, 1'b1);
        chk("err_no_rsp", rlog.size(), 0);
        tick(1'b1);
        chk("err_clear", err_o, 1'b0);

        // Reset with three words in flight
        lat = 6;
        for (int i = 0; i < 3; i++) begin rq_pend[i] = 1'b1; rq_data[i] = W'($urandom); end
        tick(1'b0); tick(1'b0); tick(1'b0);
        tick(1'b1);
        chk("rst_rsp_val", rsp_val_o, 4'b0000);
        chk("rst_pe_val", pe_data_val_o, 1'b0);
        for (int i = 0; i < N; i++) begin rq_pend[i] = 1'b1; rq_data[i] = W'($urandom); end
        tick(1'b0);
        chk("rst_next_grant", obs_rdy, 4'b0001);
        clear_reqs();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_arbiter.md
# pe_arbiter

Shares one `priority_encoder` instance between `N_REQ` independent requesters. The block arbitrates incoming search words, issues one word per cycle to the encoder, and tracks in-flight requester IDs in a tag FIFO. It routes each encoder result (leftmost/rightmost one-hot) back to the requester that issued it. It sits between the requester-side datapaths and the encoder's `data_i`/`data_val_i` and `data_left_o`/`data_right_o`/`data_val_o` ports.

## Interface
- `WIDTH`, 16, search word width; must match the encoder.
- `N_REQ`, 4, number of requesters, 2..8.
- `MAX_INFLIGHT`, 4, tag FIFO depth and maximum outstanding encoder words; power of two, ≥ 1.
- `clk_i` in 1: single clock.
- `srst_i` in 1: synchronous, active-high reset. It also drives the encoder's `srst_i`.
- `req_data_i` in `N_REQ*WIDTH`: word of requester i is at `[i*WIDTH +: WIDTH]`.
- `req_val_i` in `N_REQ`: requester i has a word pending.
- `req_rdy_o` out `N_REQ`: one-hot or zero, combinational; word i is accepted this cycle.
- `pe_data_o` out `WIDTH`: registered word to the encoder `data_i`.
- `pe_data_val_o` out 1: registered, to the encoder `data_val_i`.
- `pe_left_i` in `WIDTH`: encoder `data_left_o`.
- `pe_right_i` in `WIDTH`: encoder `data_right_o`.
- `pe_val_i` in 1: encoder `data_val_o`.
- `rsp_left_o` out `WIDTH`: registered result, leftmost set bit.
- `rsp_right_o` out `WIDTH`: registered result, rightmost set bit.
- `rsp_id_o` out `$clog2(N_REQ)`: requester owning the result.
- `rsp_val_o` out `N_REQ`: one-hot result valid, bit `rsp_id_o`.
- `err_o` out 1: sticky; set when `pe_val_i` arrives with the tag FIFO empty.

## Operation
- **Eligibility:**
  - `can_issue = (cnt < MAX_INFLIGHT) || pe_val_i`.
  - `cnt` is the tag FIFO occupancy, range 0..`MAX_INFLIGHT`.
- **Grant:**
  - When `can_issue` is set, exactly one requester with `req_val_i` set is granted: `req_rdy_o[g] = 1`.
  - Otherwise `req_rdy_o = 0`.
  - A requester holds `req_val_i` and its data stable until it sees `req_rdy_o`.
- **Arbitration:**
  - Round-robin pointer `ptr`.
  - The search starts at `ptr` and wraps modulo `N_REQ`.
  - After a grant to g, `ptr <= (g+1) % N_REQ`.
  - `ptr` holds when there is no grant.
- **Issue (same cycle as the grant):**
  - `pe_data_o <= req_data_i[g]`, `pe_data_val_o <= 1`.
  - Push g into the tag FIFO.
  - With no grant: `pe_data_val_o <= 0` and `pe_data_o` holds.
- **Return:**
  - On `pe_val_i`, pop the FIFO head h.
  - Next cycle: `rsp_left_o`/`rsp_right_o` = `pe_left_i`/`pe_right_i`, `rsp_id_o = h`, `rsp_val_o = 1 << h`.
  - Otherwise `rsp_val_o <= 0` and the data outputs hold.
- **Ordering:**
  - The encoder is in-order with fixed latency ≥ 1, so the FIFO order equals the result order.
- **Simultaneous push and pop:**
  - `cnt` is unchanged.
  - Allowed at `cnt == MAX_INFLIGHT`.
  - Read and write pointers wrap at `MAX_INFLIGHT`.
- **Error:**
  - `pe_val_i` with `cnt == 0` sets `err_o`.
  - No pop occurs and no response is generated.
  - `err_o` clears only on reset.

## Timing
- Grant to `pe_data_val_o`: 1 cycle.
- Encoder output to `rsp_val_o`: 1 cycle.
- End-to-end latency: encoder latency + 2 cycles.
- Throughput: 1 word per cycle sustained when encoder latency + 1 ≤ `MAX_INFLIGHT`.
- Reset values: `req_rdy_o = 0`, `pe_data_o = 0`, `pe_data_val_o = 0`, `rsp_left_o = 0`, `rsp_right_o = 0`, `rsp_id_o = 0`, `rsp_val_o = 0`, `err_o = 0`, `ptr = 0`, `cnt = 0`, FIFO pointers 0.
- `req_rdy_o` is 0 during every cycle in which `srst_i` is high.
- Reset mid-operation:
  - All in-flight tags are discarded.
  - The encoder is reset by the same `srst_i`, so no stale `pe_val_i` follows.
  - A stale `pe_val_i` after reset sets `err_o`.

## Configuration
- `PE_ARB_RR_EN` defined: round-robin arbitration as described above.
- `PE_ARB_RR_EN` undefined:
  - Fixed priority; the lowest requester index wins.
  - `ptr` is removed.
  - All other behaviour, latency and reset values are identical.

## Test plan
- **Single request:** `N_REQ=4`, `MAX_INFLIGHT=4`, real encoder (latency 1). Requester 2 sends `16'h0A50` → `req_rdy_o = 4'b0100` in the same cycle; `pe_data_val_o` 1 cycle later; `rsp_val_o = 4'b0100`, `rsp_left_o = 16'h0800`, `rsp_right_o = 16'h0010` 3 cycles after the grant.
- **Round-robin fairness:** all 4 requesters continuously valid for 8 cycles → grant order 0,1,2,3,0,1,2,3 with `PE_ARB_RR_EN`; without the macro, eight grants to requester 0.
- **Back-pressure:** encoder model with latency 6, `MAX_INFLIGHT=4`, continuous requests → exactly 4 issues, then `req_rdy_o = 0` until the first `pe_val_i`; the grant resumes in that same cycle (push and pop at full).
- **Result routing:** issue words `16'h0001` (req 0), `16'h8000` (req 3), `16'h0000` (req 1) → responses in order to IDs 0, 3, 1 with left/right `16'h0001/16'h0001`, `16'h8000/16'h8000`, `16'h0000/16'h0000`.
- **Error:** assert `pe_val_i` with `cnt = 0` → `err_o = 1` from the next cycle, `rsp_val_o` stays 0, `err_o` stays set until `srst_i`.
- **Reset mid-stream:** pulse `srst_i` for 1 cycle with 3 words in flight → all outputs at reset values the next cycle, `cnt = 0`, and the next grant goes to requester 0.
